bit_serial_adder: RTL and testbench



---
 rtl/arith_pkg.sv | 17 +
 rtl/bit_serial_adder_if.sv | 29 ++
 rtl/full_adder_cell.sv | 34 +++
 rtl/half_adder.sv | 15 +
 rtl/bit_serial_adder.sv | 125 ++++++++++++
 tb/tb_bit_serial_adder.sv | 290 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the widest operand size the serial adder supports.
package arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle for bit_serial_adder.
//   master (upstream/downstream logic): drives start, a, b, cin; observes
//     ready, busy, done, sum, cout.
//   slave (the adder): the reverse directions.
interface bit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_cell.sv
// Single-bit full adder built from two half adders plus an OR on the carries.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s1),
    .carry (c1)
  );

  half_adder u_ha1 (
    .a     (s1),
    .b     (cin),
    .sum   (sum),
    .carry (c2)
  );

  // The two half-adder carries are never both set, so OR gives the majority.
  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
//   a, b  : input bits
//   sum   : a ^ b
//   carry : a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: {cout,sum} = a + b + cin, one bit per clock
// through a single full-adder cell, with the carry held in a flop.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of bit_serial_adder_if
//                start/a/b/cin accepted while ready=1; busy during shifting;
//                done pulses one cycle with sum/cout valid.
// Latency: accept at E0, bits on E1..E_WIDTH, done high E_WIDTH..E_WIDTH+1.
module bit_serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_adder_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("bit_serial_adder: WIDTH out of range");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               cout_q,  cout_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ready_q, ready_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               fa_sum;
  logic               fa_cout;

  // The one arithmetic slice, fed from the LSBs of the operand shifters.
  full_adder_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // New bit enters at the MSB; concatenation keeps WIDTH=1 legal.
        sum_d   = WIDTH'({fa_sum, sum_q} >> 1);
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder at WIDTH = 8, 1 and 13.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(8))  bus8  ();
  bit_serial_adder_if #(.WIDTH(1))  bus1  ();
  bit_serial_adder_if #(.WIDTH(13)) bus13 ();

  bit_serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  bit_serial_adder #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 add with latency, result and return-to-idle checks.
  task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic ec, input string nm);
    int lat;
    bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0;
    bus8.a = ~a; bus8.b = ~b; bus8.cin = ~ci;
    lat = 0;
    while (!bus8.done && lat < 20) begin
      tick;
      lat++;
    end
    n_tests++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want 8", nm, lat);
    end
    n_tests++;
    if ({bus8.cout, bus8.sum} !== {ec, es}) begin
      n_fail++;
      $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h",
               nm, bus8.cout, bus8.sum, ec, es);
    end
    tick;
    n_tests++;
    if ({bus8.ready, bus8.busy, bus8.done} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s idle_after: got rbd=%b want 100", nm,
               {bus8.ready, bus8.busy, bus8.done});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {4'b1000, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got rbd=%b cout=%b sum=%h want rbd=100 cout=0 sum=00",
                 i, {bus8.ready, bus8.busy, bus8.done}, bus8.cout, bus8.sum);
      end
      tick;
    end
  endtask

  task automatic test_basic;
    bus8.a = 8'h3C; bus8.b = 8'h5A; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({bus8.ready, bus8.busy, bus8.done} !== 3'b010) begin
        n_fail++;
        $display("FAIL basic_busy after E%0d: got rbd=%b want 010", i,
                 {bus8.ready, bus8.busy, bus8.done});
      end
      tick;
    end
    n_tests++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {4'b0010, 8'h96}) begin
      n_fail++;
      $display("FAIL basic_done: got rbd=%b cout=%b sum=%h want rbd=001 cout=0 sum=96",
               {bus8.ready, bus8.busy, bus8.done}, bus8.cout, bus8.sum);
    end
    tick;
    n_tests++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.sum} !== {3'b100, 8'h96}) begin
      n_fail++;
      $display("FAIL basic_idle: got rbd=%b sum=%h want rbd=100 sum=96",
               {bus8.ready, bus8.busy, bus8.done}, bus8.sum);
    end
  endtask

  task automatic test_carry;
    do_add8(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, "ff_01_1");
    do_add8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80_80_0");
    do_add8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "00_00_0");
    do_add8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_1");
    for (int i = 0; i < 3; i++) tick;
    n_tests++;
    if ({bus8.cout, bus8.sum, bus8.ready} !== {1'b1, 8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_result: got cout=%b sum=%h ready=%b want cout=1 sum=ff ready=1",
               bus8.cout, bus8.sum, bus8.ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] q[$];
    logic [8:0] exp;
    int last_done = -1;
    int n_acc = 0;
    int n_done = 0;
    int k;
    bus8.start = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      bus8.a = 8'(c * 37 + 5);
      bus8.b = 8'(c * 91 + 200);
      bus8.cin = c[0];
      if (bus8.ready) begin
        q.push_back(9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin));
        n_acc++;
      end
      tick;
      n_tests++;
      if ($countones({bus8.ready, bus8.busy, bus8.done}) != 1) begin
        n_fail++;
        $display("FAIL b2b_onehot c%0d: got rbd=%b want one bit set", c,
                 {bus8.ready, bus8.busy, bus8.done});
      end
      if (bus8.done) begin
        n_done++;
        exp = (q.size() > 0) ? q.pop_front() : 9'h1xx;
        n_tests++;
        if ({bus8.cout, bus8.sum} !== exp) begin
          n_fail++;
          $display("FAIL b2b_result c%0d: got %h want %h", c, {bus8.cout, bus8.sum}, exp);
        end
        if (last_done >= 0) begin
          n_tests++;
          if (c - last_done != 10) begin
            n_fail++;
            $display("FAIL b2b_spacing c%0d: got %0d want 10", c, c - last_done);
          end
        end
        last_done = c;
      end
    end
    bus8.start = 1'b0;
    k = 0;
    while (q.size() > 0 && k < 12) begin
      tick;
      k++;
      if (bus8.done) begin
        n_done++;
        exp = q.pop_front();
        n_tests++;
        if ({bus8.cout, bus8.sum} !== exp) begin
          n_fail++;
          $display("FAIL b2b_drain: got %h want %h", {bus8.cout, bus8.sum}, exp);
        end
      end
    end
    tick;
    n_tests++;
    if (n_acc !== 5 || n_done !== 5) begin
      n_fail++;
      $display("FAIL b2b_count: got accepts=%0d dones=%0d want 5/5", n_acc, n_done);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    bus8.a = 8'h3C; bus8.b = 8'h5A; bus8.cin = 1'b1; bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0;
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_tests++;
    if ({bus8.ready, bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {4'b1000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid: got rbd=%b cout=%b sum=%h want rbd=100 cout=0 sum=00",
               {bus8.ready, bus8.busy, bus8.done}, bus8.cout, bus8.sum);
    end
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus8.done || !bus8.ready) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d non-idle cycles want 0", dones);
    end
    do_add8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after_reset");
  endtask

  task automatic test_width1;
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.start = 1'b1;
    tick;
    bus1.start = 1'b0;
    n_tests++;
    if ({bus1.ready, bus1.busy, bus1.done} !== 3'b010) begin
      n_fail++;
      $display("FAIL w1_busy: got rbd=%b want 010", {bus1.ready, bus1.busy, bus1.done});
    end
    tick;
    n_tests++;
    if ({bus1.ready, bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 5'b00111) begin
      n_fail++;
      $display("FAIL w1_done: got rbd=%b cout=%b sum=%b want rbd=001 cout=1 sum=1",
               {bus1.ready, bus1.busy, bus1.done}, bus1.cout, bus1.sum);
    end
    tick;
    n_tests++;
    if ({bus1.ready, bus1.busy, bus1.done} !== 3'b100) begin
      n_fail++;
      $display("FAIL w1_idle: got rbd=%b want 100", {bus1.ready, bus1.busy, bus1.done});
    end
  endtask

  task automatic test_random;
    logic [7:0]  a8, b8;
    logic [12:0] a13, b13;
    logic        ci;
    int          k;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci = 1'($urandom);
      bus8.a = a8; bus8.b = b8; bus8.cin = ci; bus8.start = 1'b1;
      tick;
      bus8.start = 1'b0;
      k = 0;
      while (!bus8.done && k < 20) begin tick; k++; end
      n_tests++;
      if ({bus8.cout, bus8.sum} !== (9'(a8) + 9'(b8) + 9'(ci)) || k != 8) begin
        n_fail++;
        $display("FAIL rand8 %h+%h+%b: got %h lat=%0d want %h lat=8", a8, b8, ci,
                 {bus8.cout, bus8.sum}, k, 9'(a8) + 9'(b8) + 9'(ci));
      end
      tick;
    end
    for (int i = 0; i < 1000; i++) begin
      a13 = 13'($urandom); b13 = 13'($urandom); ci = 1'($urandom);
      bus13.a = a13; bus13.b = b13; bus13.cin = ci; bus13.start = 1'b1;
      tick;
      bus13.start = 1'b0;
      k = 0;
      while (!bus13.done && k < 30) begin tick; k++; end
      n_tests++;
      if ({bus13.cout, bus13.sum} !== (14'(a13) + 14'(b13) + 14'(ci)) || k != 13) begin
        n_fail++;
        $display("FAIL rand13 %h+%h+%b: got %h lat=%0d want %h lat=13", a13, b13, ci,
                 {bus13.cout, bus13.sum}, k, 14'(a13) + 14'(b13) + 14'(ci));
      end
      tick;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
    bus1.start  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.cin  = 1'b0;
    bus13.start = 1'b0; bus13.a = '0; bus13.b = '0; bus13.cin = 1'b0;
    test_reset;
    test_basic;
    test_carry;
    test_back_to_back;
    test_reset_mid;
    test_width1;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
